// File: rtl/btb_update_controller.sv
// BTB write-port controller: arbitrates branch/jump updates into the BTB and runs the
// invalidation sweep. Define BTB_UPDATE_STATS_EN to build the committed-update counter.
module btb_update_controller #(
    parameter int LOWER = 5
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               br_valid_i,
    output logic               br_ready_o,
    input  logic [63:0]        br_pc_i,
    input  logic [63:0]        br_target_i,
    input  logic               jmp_valid_i,
    output logic               jmp_ready_o,
    input  logic [63:0]        jmp_pc_i,
    input  logic [63:0]        jmp_target_i,
    input  logic               flush_req_i,
    output logic               wr_en_o,
    output logic [LOWER-1:0]   wr_index_o,
    output logic [127:0]       wr_data_o,
    output logic               sweeping_o,
    output logic               flush_done_o,
    output logic [31:0]        upd_count_o
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [LOWER-1:0] IDX_MAX = '1;

    state_t           state_q, state_d;
    logic [LOWER-1:0] sweep_idx_q, sweep_idx_d;
    logic             hold_q;
    logic             flush_done_q, flush_done_d;
    logic             pend_br_q, pend_br_d;
    logic             pend_jmp_q, pend_jmp_d;
    logic [63:0]      br_pc_q, br_pc_d, br_tgt_q, br_tgt_d;
    logic [63:0]      jmp_pc_q, jmp_pc_d, jmp_tgt_q, jmp_tgt_d;
    logic             last_grant_q, last_grant_d;  // 1: jump won last, 0: branch won last

    logic idle;
    logic both_pend;
    logic same_idx;
    logic grant_jmp;
    logic grant_br;
    logic br_acc;
    logic jmp_acc;

    assign idle      = (state_q == ST_IDLE);
    assign both_pend = pend_br_q && pend_jmp_q;
    assign same_idx  = both_pend && (br_pc_q[LOWER-1:0] == jmp_pc_q[LOWER-1:0]);
    assign grant_jmp = idle && pend_jmp_q && (!pend_br_q || same_idx || !last_grant_q);
    assign grant_br  = idle && pend_br_q && !grant_jmp;

    assign jmp_ready_o = idle && !flush_req_i;
    assign br_ready_o  = idle && !flush_req_i && !both_pend;
    assign br_acc      = br_valid_i && br_ready_o;
    assign jmp_acc     = jmp_valid_i && jmp_ready_o;

    // hold_q masks the first cycle after a reset edge so outputs stay quiet while reset is held
    assign sweeping_o   = (state_q == ST_SWEEP) && !hold_q;
    assign flush_done_o = flush_done_q;

    always_comb begin
        wr_en_o    = 1'b0;
        wr_index_o = '0;
        wr_data_o  = '0;
        if (sweeping_o) begin
            wr_en_o    = 1'b1;
            wr_index_o = sweep_idx_q;
        end else if (grant_jmp) begin
            wr_en_o    = 1'b1;
            wr_index_o = jmp_pc_q[LOWER-1:0];
            wr_data_o  = {jmp_pc_q, jmp_tgt_q};
        end else if (grant_br) begin
            wr_en_o    = 1'b1;
            wr_index_o = br_pc_q[LOWER-1:0];
            wr_data_o  = {br_pc_q, br_tgt_q};
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_idx_d  = sweep_idx_q;
        flush_done_d = 1'b0;
        pend_br_d    = pend_br_q;
        pend_jmp_d   = pend_jmp_q;
        br_pc_d      = br_pc_q;
        br_tgt_d     = br_tgt_q;
        jmp_pc_d     = jmp_pc_q;
        jmp_tgt_d    = jmp_tgt_q;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_SWEEP: begin
                if (!hold_q) begin
                    if (sweep_idx_q == IDX_MAX) begin
                        state_d      = ST_IDLE;
                        sweep_idx_d  = '0;
                        flush_done_d = 1'b1;
                    end else begin
                        sweep_idx_d = sweep_idx_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (grant_jmp) begin
                    pend_jmp_d   = 1'b0;
                    last_grant_d = 1'b1;
                    // same-row collision: the jump supersedes the branch
                    if (same_idx) pend_br_d = 1'b0;
                end
                if (grant_br) begin
                    pend_br_d    = 1'b0;
                    last_grant_d = 1'b0;
                end
                if (br_acc) begin
                    pend_br_d = 1'b1;
                    br_pc_d   = br_pc_i;
                    br_tgt_d  = br_target_i;
                end
                if (jmp_acc) begin
                    pend_jmp_d = 1'b1;
                    jmp_pc_d   = jmp_pc_i;
                    jmp_tgt_d  = jmp_target_i;
                end
            end
            default: state_d = ST_SWEEP;
        endcase

        if (flush_req_i) begin
            state_d      = ST_SWEEP;
            sweep_idx_d  = '0;
            flush_done_d = 1'b0;
            pend_br_d    = 1'b0;
            pend_jmp_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            state_q      <= ST_SWEEP;
            sweep_idx_q  <= '0;
            hold_q       <= 1'b1;
            flush_done_q <= 1'b0;
            pend_br_q    <= 1'b0;
            pend_jmp_q   <= 1'b0;
            br_pc_q      <= '0;
            br_tgt_q     <= '0;
            jmp_pc_q     <= '0;
            jmp_tgt_q    <= '0;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            hold_q       <= 1'b0;
            flush_done_q <= flush_done_d;
            pend_br_q    <= pend_br_d;
            pend_jmp_q   <= pend_jmp_d;
            br_pc_q      <= br_pc_d;
            br_tgt_q     <= br_tgt_d;
            jmp_pc_q     <= jmp_pc_d;
            jmp_tgt_q    <= jmp_tgt_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef BTB_UPDATE_STATS_EN
    logic [31:0] upd_count_q, upd_count_d;
    logic        upd_write;

    assign upd_write = grant_jmp || grant_br;

    always_comb begin
        upd_count_d = upd_count_q;
        if (upd_write && (upd_count_q != 32'hFFFF_FFFF)) upd_count_d = upd_count_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) upd_count_q <= '0;
        else           upd_count_q <= upd_count_d;
    end

    assign upd_count_o = upd_count_q;
`else
    assign upd_count_o = '0;
`endif

endmodule

// File: tb/tb_btb_update_controller.sv
// Directed self-checking bench for btb_update_controller (default LOWER=5).
module tb_btb_update_controller;
    localparam int LOWER = 5;

`ifdef BTB_UPDATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               arst_n;
    logic               br_valid, br_ready, jmp_valid, jmp_ready, flush_req;
    logic [63:0]        br_pc, br_target, jmp_pc, jmp_target;
    logic               wr_en, sweeping, flush_done;
    logic [LOWER-1:0]   wr_index;
    logic [127:0]       wr_data;
    logic [31:0]        upd_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt      = 0;

    always #5 clk = ~clk;

    btb_update_controller #(.LOWER(LOWER)) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .br_valid_i   (br_valid),
        .br_ready_o   (br_ready),
        .br_pc_i      (br_pc),
        .br_target_i  (br_target),
        .jmp_valid_i  (jmp_valid),
        .jmp_ready_o  (jmp_ready),
        .jmp_pc_i     (jmp_pc),
        .jmp_target_i (jmp_target),
        .flush_req_i  (flush_req),
        .wr_en_o      (wr_en),
        .wr_index_o   (wr_index),
        .wr_data_o    (wr_data),
        .sweeping_o   (sweeping),
        .flush_done_o (flush_done),
        .upd_count_o  (upd_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [LOWER-1:0] idx,
                          input logic [127:0] data);
        $display("%s: wr_en=%0b wr_index=%0d wr_data=%0h", tag, wr_en, wr_index, wr_data);
        chk({tag, "_en"}, 128'(wr_en), 128'(en));
        chk({tag, "_idx"}, 128'(wr_index), 128'(idx));
        chk({tag, "_data"}, wr_data, data);
    endtask

    task automatic chk_sweep(input string tag, input int idx);
        $display("%s: sweep write idx=%0d", tag, wr_index);
        chk($sformatf("%s_sweeping%0d", tag, idx), 128'(sweeping), 128'(1'b1));
        chk($sformatf("%s_en%0d", tag, idx), 128'(wr_en), 128'(1'b1));
        chk($sformatf("%s_idx%0d", tag, idx), 128'(wr_index), 128'(idx));
        chk($sformatf("%s_data%0d", tag, idx), wr_data, 128'd0);
        chk($sformatf("%s_brrdy%0d", tag, idx), 128'(br_ready), 128'(1'b0));
        chk($sformatf("%s_jmprdy%0d", tag, idx), 128'(jmp_ready), 128'(1'b0));
        chk($sformatf("%s_done%0d", tag, idx), 128'(flush_done), 128'(1'b0));
    endtask

    task automatic chk_sweep_end(input string tag);
        $display("%s: flush_done=%0b sweeping=%0b", tag, flush_done, sweeping);
        chk({tag, "_done"}, 128'(flush_done), 128'(1'b1));
        chk({tag, "_sweeping"}, 128'(sweeping), 128'(1'b0));
        chk({tag, "_en"}, 128'(wr_en), 128'(1'b0));
        chk({tag, "_brrdy"}, 128'(br_ready), 128'(1'b1));
        chk({tag, "_count"}, 128'(upd_count), STATS ? 128'(cnt) : 128'd0);
    endtask

    logic exp_rdy [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   exp_src [8] = '{0, 1, 2, 1, 2, 1, 2, 0};

    initial begin
        arst_n = 1'b0; br_valid = 1'b0; jmp_valid = 1'b0; flush_req = 1'b0;
        br_pc = '0; br_target = '0; jmp_pc = '0; jmp_target = '0;

        // reset held low
        tick(); tick();
        $display("reset: wr_en=%0b sweeping=%0b", wr_en, sweeping);
        chk("rst_wr", 128'(wr_en), 128'd0);
        chk("rst_idx", 128'(wr_index), 128'd0);
        chk("rst_data", wr_data, 128'd0);
        chk("rst_sweeping", 128'(sweeping), 128'd0);
        chk("rst_done", 128'(flush_done), 128'd0);
        chk("rst_brrdy", 128'(br_ready), 128'd0);
        chk("rst_jmprdy", 128'(jmp_ready), 128'd0);
        chk("rst_count", 128'(upd_count), 128'd0);

        // release: full power-on sweep
        arst_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            chk_sweep("init", i);
            tick();
        end
        chk_sweep_end("init_end");

        // single branch
        br_valid = 1'b1; br_pc = 64'h1004; br_target = 64'h2000;
        #1 chk("single_brrdy", 128'(br_ready), 128'd1);
        tick();
        br_valid = 1'b0;
        cnt++;
        chk_wr("single", 1'b1, 5'd4, {64'h1004, 64'h2000});
        chk("single_count", 128'(upd_count), STATS ? 128'(cnt) : 128'd0);
        tick();
        chk_wr("single_after", 1'b0, 5'd0, 128'd0);

        // same-index collision: jump wins, branch dropped
        br_valid = 1'b1; br_pc = 64'h40; br_target = 64'h111;
        jmp_valid = 1'b1; jmp_pc = 64'h80; jmp_target = 64'h222;
        #1 chk("coll_brrdy", 128'(br_ready), 128'd1);
        chk("coll_jmprdy", 128'(jmp_ready), 128'd1);
        tick();
        br_valid = 1'b0; jmp_valid = 1'b0;
        cnt++;
        chk_wr("coll", 1'b1, 5'd0, {64'h80, 64'h222});
        tick();
        chk_wr("coll_after", 1'b0, 5'd0, 128'd0);
        chk("coll_count", 128'(upd_count), STATS ? 128'(cnt) : 128'd0);

        // different-index contention, jump won last so branch goes first
        br_pc = 64'h1001; br_target = 64'hAAAA;
        jmp_pc = 64'h2002; jmp_target = 64'hBBBB;
        for (int c = 0; c < 8; c++) begin
            br_valid = (c < 6); jmp_valid = (c < 6);
            #1;
            chk($sformatf("cont_brrdy%0d", c), 128'(br_ready), 128'(exp_rdy[c]));
            chk($sformatf("cont_jmprdy%0d", c), 128'(jmp_ready), 128'd1);
            case (exp_src[c])
                1:       chk_wr($sformatf("cont_c%0d", c), 1'b1, 5'd1, {64'h1001, 64'hAAAA});
                2:       chk_wr($sformatf("cont_c%0d", c), 1'b1, 5'd2, {64'h2002, 64'hBBBB});
                default: chk_wr($sformatf("cont_c%0d", c), 1'b0, 5'd0, 128'd0);
            endcase
            if (exp_src[c] != 0) cnt++;
            tick();
        end
        chk("cont_count", 128'(upd_count), STATS ? 128'(cnt) : 128'd0);

        // flush while a branch waits behind a jump
        br_valid = 1'b1; br_pc = 64'h1005; br_target = 64'hC5;
        tick();
        br_pc = 64'h1006; br_target = 64'hC6;
        jmp_valid = 1'b1; jmp_pc = 64'h2007; jmp_target = 64'hD7;
        #1 chk("fl_brrdy", 128'(br_ready), 128'd1);
        cnt++;
        chk_wr("fl_b5", 1'b1, 5'd5, {64'h1005, 64'hC5});
        tick();
        br_valid = 1'b0; jmp_valid = 1'b0; flush_req = 1'b1;
        #1 chk("fl_brrdy_flush", 128'(br_ready), 128'd0);
        chk("fl_jmprdy_flush", 128'(jmp_ready), 128'd0);
        cnt++;
        chk_wr("fl_j7", 1'b1, 5'd7, {64'h2007, 64'hD7});
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk_sweep("fl", i);
            tick();
        end
        chk_sweep_end("fl_end");

        // mid-sweep flush at index 10
        flush_req = 1'b1;
        #1 chk("mid_jmprdy", 128'(jmp_ready), 128'd0);
        tick();
        flush_req = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            chk_sweep("mid_a", i);
            if (i == 10) flush_req = 1'b1;
            tick();
        end
        flush_req = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk_sweep("mid_b", i);
            tick();
        end
        chk_sweep_end("mid_end");

        // reset with an update in flight
        br_valid = 1'b1; br_pc = 64'h100A; br_target = 64'hEE;
        tick();
        br_valid = 1'b0; arst_n = 1'b0;
        tick();
        cnt = 0;
        chk_wr("rst2", 1'b0, 5'd0, 128'd0);
        chk("rst2_sweeping", 128'(sweeping), 128'd0);
        chk("rst2_count", 128'(upd_count), 128'd0);
        arst_n = 1'b1;
        tick();
        chk_sweep("rst2", 0);
        tick();
        chk_sweep("rst2", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/btb_update_controller.md
# btb_update_controller

Sequences all writes into the branch target buffer storage through one shared write port. It arbitrates update requests from two sources: taken-branch resolution and jump resolution. It also runs the invalidation sweep that clears every entry after reset or on a pipeline flush. It sits between the resolution stages and the BTB state array, and is the only writer of that array.

## Interface
- LOWER, 5, index width; the BTB has 2^LOWER entries
- clk  in  1  clock, rising edge
- arst_n  in  1  reset; synchronous, active-low
- br_valid  in  1  taken-branch update request
- br_ready  out  1  branch request accepted when br_valid && br_ready
- br_pc  in  64  PC of the branch instruction (tag; index = br_pc[LOWER-1:0])
- br_target  in  64  branch target
- jmp_valid  in  1  jump update request
- jmp_ready  out  1  jump request accepted when jmp_valid && jmp_ready
- jmp_pc  in  64  PC of the jump instruction
- jmp_target  in  64  jump target
- flush_req  in  1  start an invalidation sweep
- wr_en  out  1  BTB write strobe
- wr_index  out  LOWER  BTB row to write
- wr_data  out  128  {tag_pc[63:0], target[63:0]}
- sweeping  out  1  sweep in progress
- flush_done  out  1  one-cycle pulse after the last sweep write
- upd_count  out  32  committed update count (see Configuration)

## Operation
- State machine: SWEEP, IDLE.
- Reset (arst_n=0 at an edge) does the following:
  - state=SWEEP, sweep_idx=0.
  - Both pending registers are cleared, last_grant=0, upd_count=0.
- SWEEP state:
  - wr_en=1, wr_index=sweep_idx, wr_data=0. sweep_idx increments each cycle.
  - After the write at index 2^LOWER-1, the next state is IDLE and flush_done is 1 for that first IDLE cycle.
  - br_ready=jmp_ready=0 throughout SWEEP.
- IDLE state:
  - jmp_ready = !flush_req.
  - br_ready = !flush_req && (!pend_br || !pend_jmp).
  - An accepted request is stored in its source's 1-entry pending register (pend_br or pend_jmp, holding pc and target).
- Grant, evaluated combinationally from the pending registers each IDLE cycle:
  - Only pend_jmp full: write jump.
  - Only pend_br full: write branch.
  - Both full, different index: round-robin. The source not granted last time wins; last_grant records the winner.
  - Both full, same index: write jump and discard branch. Both registers clear and only one write is counted.
  - The granted register clears at the edge. A new request from that source may fill it in the same cycle.
- wr_en=0, wr_index=0 and wr_data=0 when nothing is pending in IDLE.
- flush_req in IDLE or SWEEP: the next state is SWEEP with sweep_idx=0, and both pending registers are cleared. In-flight updates are discarded and a sweep already running restarts.
- Reset mid-sweep or mid-update: same as power-on reset; the sweep restarts from index 0.

## Timing
- Values while arst_n is held low: wr_en=0, wr_index=0, wr_data=0, sweeping=0, flush_done=0, br_ready=0, jmp_ready=0, upd_count=0.
- First cycle after release: sweeping=1, wr_en=1, wr_index=0.
- A full sweep takes exactly 2^LOWER cycles (32 at default). flush_done pulses in cycle 2^LOWER after sweep start.
- Update latency: a request accepted at edge t has wr_en high in the cycle after t. Contention delays it by one cycle per losing arbitration.
- wr_*, sweeping and flush_done are decoded from registered state only. The ready outputs depend combinationally on flush_req.
- Throughput: one write per cycle. Sustained dual requests alternate, so no source starves.

## Configuration
- BTB_UPDATE_STATS_EN defined: upd_count increments on each non-sweep write, saturating at 32'hFFFF_FFFF. Sweeps do not clear it; only reset does.
- BTB_UPDATE_STATS_EN undefined: upd_count is tied to 0 and no counter is built.

## Test plan
- Reset release: expect sweeping=1 and wr_en=1 for 32 cycles with wr_index 0..31 and wr_data=0, then flush_done=1 for one cycle and sweeping=0.
- Single branch: br_pc=0x1004, br_target=0x2000 accepted. Next cycle expect wr_en=1, wr_index=4, wr_data={0x1004,0x2000}, and upd_count=1 (STATS_EN).
- Same-index collision: br_pc=0x40 and jmp_pc=0x80 accepted together with LOWER=5. Expect exactly one write, wr_index=0 with the jump data; the branch is dropped and upd_count increments by 1.
- Different-index contention: branch and jump requested every cycle for 6 cycles. Expect wr_data to alternate between sources and br_ready to drop only while both pending registers are full.
- Flush with pending work: flush_req pulses while pend_br is full. Expect no write of the pending branch, a full 32-cycle sweep, and ready=0 until flush_done.
- Mid-sweep flush: flush_req at sweep index 10. Expect the next wr_index=0 and the sweep to run a further 32 writes.
